// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: access sizes,
// FSM state encoding and the default memory geometry.
package mem_pkg;

  localparam int DM_ADDR_BITS_DEF = 12;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_ILL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dm_lane_align.sv
// Pure combinational lane logic: store byte-enables and replicated data,
// load alignment and extension, and size/alignment legality check.
module dm_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_chk_size,
  input  logic [1:0]  i_chk_off,
  output logic        o_chk_fault,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_dout,
  output logic [3:0]  o_wbe,
  output logic [31:0] o_din,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  assign w_shift = i_dout >> {i_off, 3'b000};

  assign o_chk_fault = (i_chk_size == SIZE_ILL)
                     | ((i_chk_size == SIZE_HALF) & i_chk_off[0])
                     | ((i_chk_size == SIZE_WORD) & (i_chk_off != 2'b00));

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    o_wbe   = 4'b0000;
    o_din   = i_wdata;
    o_rdata = 32'h0;
    case (i_size)
      SIZE_BYTE: begin
        o_wbe   = 4'b0001 << i_off;
        o_din   = {4{i_wdata[7:0]}};
        o_rdata = i_unsigned ? {24'h0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      SIZE_HALF: begin
        o_wbe   = 4'b0011 << i_off;
        o_din   = {2{i_wdata[15:0]}};
        o_rdata = i_unsigned ? {16'h0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      SIZE_WORD: begin
        o_wbe   = 4'b1111;
        o_din   = i_wdata;
        o_rdata = w_shift;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// Load/store front end for the word-addressed data memory: accepts one
// byte-addressed request, performs a single-cycle memory access, then responds.
module dm_access_unit
  import mem_pkg::*;
#(
  parameter int          DM_ADDR_BITS = DM_ADDR_BITS_DEF,
  parameter logic [31:0] DM_BASE      = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_fault,
  output logic [DM_ADDR_BITS-3:0] dm_addr,
  output logic [31:0]             dm_din,
  output logic                    dm_we,
  output logic [3:0]              dm_wbyte_enable,
  input  logic [31:0]             dm_dout
);

  state_t r_state, w_state_nxt;

  logic                    r_we;
  logic [1:0]              r_size;
  logic                    r_unsigned;
  logic                    r_fault;
  logic [DM_ADDR_BITS-3:0] r_waddr;
  logic [1:0]              r_off;
  logic [31:0]             r_wdata;
  logic [31:0]             r_rdata;

  logic [31:0] w_offset;
  logic        w_range_fault;
  logic        w_align_fault;
  logic [3:0]  w_wbe;
  logic [31:0] w_din;
  logic [31:0] w_ld_rdata;

  // Addresses below DM_BASE wrap to huge offsets and land in the range fault.
  assign w_offset      = req_addr - DM_BASE;
  assign w_range_fault = |w_offset[31:DM_ADDR_BITS];

  dm_lane_align u_lane (
    .i_chk_size  (req_size),
    .i_chk_off   (w_offset[1:0]),
    .o_chk_fault (w_align_fault),
    .i_size      (r_size),
    .i_off       (r_off),
    .i_unsigned  (r_unsigned),
    .i_wdata     (r_wdata),
    .i_dout      (dm_dout),
    .o_wbe       (w_wbe),
    .o_din       (w_din),
    .o_rdata     (w_ld_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_fault    <= 1'b0;
      r_waddr    <= '0;
      r_off      <= 2'b00;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
    end else if (r_state == IDLE && req_valid) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_fault    <= w_range_fault | w_align_fault;
      r_waddr    <= w_offset[DM_ADDR_BITS-1:2];
      r_off      <= w_offset[1:0];
      r_wdata    <= req_wdata;
    end else if (r_state == ACCESS) begin
      r_rdata <= (r_we || r_fault) ? 32'h0 : w_ld_rdata;
    end
  end

  // Memory strobes decode only from registered state, never from req_*.
  assign dm_we           = (r_state == ACCESS) & r_we & ~r_fault;
  assign dm_wbyte_enable = dm_we ? w_wbe : 4'b0000;
  assign dm_addr         = r_waddr;
  assign dm_din          = w_din;

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_fault = (r_state == RESP) & r_fault;
  assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_dm_access_unit.sv
// Randomized and directed bench for dm_access_unit against a byte-array
// reference model of the data memory.
module tb_dm_access_unit;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din, dm_dout;
  logic        dm_we;
  logic [3:0]  dm_wbyte_enable;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] tb_mem  [1024];
  logic [7:0]  ref_mem [4096];

  always #5 clk = ~clk;

  dm_access_unit #(.DM_ADDR_BITS(12), .DM_BASE(BASE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_fault      (resp_fault),
    .dm_addr         (dm_addr),
    .dm_din          (dm_din),
    .dm_we           (dm_we),
    .dm_wbyte_enable (dm_wbyte_enable),
    .dm_dout         (dm_dout)
  );

  assign dm_dout = tb_mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we)
      for (int b = 0; b < 4; b++)
        if (dm_wbyte_enable[b]) tb_mem[dm_addr][8*b +: 8] <= dm_din[8*b +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic bit exp_fault(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return (size == 2'd3) || (size == 2'd1 && addr[0]) ||
           (size == 2'd2 && addr[1:0] != 2'b00) || (off >= 32'd4096);
  endfunction

  task automatic scramble_req();
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // Called at a falling edge with the unit idle; returns at a falling edge, idle again.
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bit          f;
    int          n, wait_cnt;
    logic [31:0] off, raw, erd, edin;
    logic [3:0]  ebe;
    f    = exp_fault(size, addr);
    off  = addr - BASE;
    n    = 1 << size;
    ebe  = 4'b0000;
    edin = 32'h0;
    erd  = 32'h0;
    raw  = 32'h0;
    if (!f) begin
      for (int k = 0; k < n; k++) begin
        if (we) begin
          ebe[off[1:0] + k] = 1'b1;
          edin[8*(off[1:0]+k) +: 8] = wdata[8*k +: 8];
        end else begin
          raw[8*k +: 8] = ref_mem[off[11:0] + k];
        end
      end
      if (we) for (int b = 0; b < 4; b++) if (!ebe[b]) edin[8*b +: 8] = wdata[8*((b - off[1:0]) % n) +: 8];
      erd = raw;
      if (!we && !uns && n < 4 && raw[8*n-1]) erd = raw | (32'hFFFF_FFFF << (8*n));
    end
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!req_ready) begin
      check("ready_timeout", {31'h0, req_ready}, 32'h1);
      return;
    end
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    scramble_req();
    check("acc_ready", {31'h0, req_ready}, 32'h0);
    check("acc_we", {31'h0, dm_we}, {31'h0, we && !f});
    check("acc_wbe", {28'h0, dm_wbyte_enable}, {28'h0, ebe});
    check("acc_resp_valid", {31'h0, resp_valid}, 32'h0);
    if (!f) check("acc_addr", {22'h0, dm_addr}, {22'h0, off[11:2]});
    if (we && !f) begin
      check("acc_din", dm_din, edin);
      for (int k = 0; k < n; k++) ref_mem[off[11:0] + k] = wdata[8*k +: 8];
    end
    @(negedge clk);
    check("resp_valid", {31'h0, resp_valid}, 32'h1);
    check("resp_fault", {31'h0, resp_fault}, {31'h0, f});
    check("resp_rdata", resp_rdata, erd);
    check("resp_we", {31'h0, dm_we}, 32'h0);
    check("resp_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    check("idle_ready", {31'h0, req_ready}, 32'h1);
    check("idle_resp_valid", {31'h0, resp_valid}, 32'h0);
  endtask

  task automatic check_mem_image(input string tag);
    int bad_words;
    bad_words = 0;
    for (int w = 0; w < 1024; w++)
      if (tb_mem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]})
        bad_words++;
    check(tag, bad_words, 0);
  endtask

  initial begin
    logic [31:0] w, a, saved;
    logic [1:0]  s;
    int          n_acc, n_rsp, ready_bad, rv_bad, r;

    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      tb_mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = w[8*b +: 8];
    end
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_fault", {31'h0, resp_fault}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_dm_we", {31'h0, dm_we}, 32'h0);
    check("rst_wbe", {28'h0, dm_wbyte_enable}, 32'h0);
    check("rst_dm_addr", {22'h0, dm_addr}, 32'h0);
    check("rst_dm_din", dm_din, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1, 2'd2, 0, 32'h10, 32'h1122_3344);
    do_req(0, 2'd2, 0, 32'h10, 32'h0);
    check("word_load_value", resp_rdata, 32'h1122_3344);
    do_req(1, 2'd0, 0, 32'h13, 32'h0000_00AB);
    do_req(0, 2'd0, 0, 32'h13, 32'h0);
    do_req(0, 2'd0, 1, 32'h13, 32'h0);
    do_req(0, 2'd2, 0, 32'h10, 32'h0);
    check("byte_merge_value", resp_rdata, 32'hAB22_3344);
    do_req(1, 2'd1, 0, 32'h22, 32'h0000_8001);
    do_req(0, 2'd1, 0, 32'h22, 32'h0);
    do_req(0, 2'd1, 1, 32'h22, 32'h0);
    do_req(1, 2'd2, 0, 32'h06, 32'hDEAD_BEEF);
    do_req(0, 2'd1, 0, 32'h01, 32'h0);
    do_req(1, 2'd3, 0, 32'h00, 32'hCAFE_F00D);
    do_req(1, 2'd2, 0, 32'h1000, 32'h1234_5678);
    check_mem_image("mem_after_directed");

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      s = ($urandom_range(0, 9) == 9) ? 2'd3 : 2'($urandom_range(0, 2));
      if (r == 0)      a = 32'h1000 + $urandom_range(0, 255);
      else if (r == 1) a = $urandom;
      else             a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0 && s != 2'd3) a = a & ~((32'h1 << s) - 1);
      do_req(1'($urandom), s, 1'($urandom), a, $urandom);
    end
    check_mem_image("mem_after_random");

    // Back-to-back loads with req_valid held high.
    n_acc = 0; n_rsp = 0; ready_bad = 0;
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (req_ready !== (i % 3 == 0)) ready_bad++;
      if (req_ready) n_acc++;
      if (resp_valid) begin
        n_rsp++;
        check("b2b_rdata", resp_rdata,
              {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]});
      end
      if (i == 14) req_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_accepts", n_acc, 5);
    check("b2b_responses", n_rsp, 5);
    check("b2b_ready_pattern", ready_bad, 0);
    check("b2b_idle_after", {31'h0, req_ready}, 32'h1);

    // Reset while a store sits in ACCESS.
    saved = tb_mem[16];
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = ~saved;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid_we_before", {31'h0, dm_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_we_drop", {31'h0, dm_we}, 32'h0);
    rv_bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) rv_bad++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid !== 1'b0) rv_bad++;
      @(negedge clk);
    end
    check("rst_mid_no_resp", rv_bad, 0);
    check("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    check("rst_mid_word_kept", tb_mem[16], saved);
    check_mem_image("mem_after_reset");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- Load/store front end that sits directly upstream of the 4 KiB word-addressed data memory.
- Accepts byte-addressed load/store requests from the CPU. Converts them into a word address, byte-lane write enables and lane-replicated write data.
- Aligns and sign/zero-extends read data.
- Detects misaligned, out-of-range and illegal-size accesses and reports them as faults instead of touching memory.

Parameters:
- DM_ADDR_BITS, 12, byte-address width of the data memory (4096 bytes); bits [DM_ADDR_BITS-1:2] form the word address.
- DM_BASE, 32'h0000_0000, byte address mapped to data-memory word 0; must be 4 KiB aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  valid with resp_valid; access was rejected.
- dm_addr  out  10  word address to the memory ([11:2]).
- dm_din  out  32  lane-replicated write data.
- dm_we  out  1  memory write enable.
- dm_wbyte_enable  out  4  byte-lane enables.
- dm_dout  in  32  combinational read data from the memory.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state:
  - state = IDLE.
  - All request registers cleared.
  - req_ready = 1, resp_valid = 0, resp_fault = 0, resp_rdata = 0.
  - dm_we = 0, dm_wbyte_enable = 0, dm_addr = 0, dm_din = 0.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: req_ready = 1. On req_valid, capture the request and the fault flag, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: always goes to RESP next cycle.
    - dm_addr, dm_din and dm_wbyte_enable are driven from the captured registers.
    - dm_we = captured_we & ~captured_fault, decoded from the state register (no combinational path from req_*).
    - The memory write commits on the clock edge that ends ACCESS.
    - For loads, aligned/extended dm_dout is captured into resp_rdata on that same edge.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- Latency and throughput: a request accepted at edge T gives resp_valid high in cycle T+2. At most one request per 3 cycles; req_ready = 0 in ACCESS and RESP.
- Fault rules, evaluated at accept:
  - size 3 is illegal.
  - Half access with addr[0] = 1 is misaligned.
  - Word access with addr[1:0] != 0 is misaligned.
  - Out of range: addr - DM_BASE >= 2**DM_ADDR_BITS (unsigned compare; addresses below DM_BASE wrap and therefore fault).
  - On any fault: no write, resp_rdata = 0, resp_fault = 1.
- Write lanes, with off = addr[1:0]:
  - byte: enable 4'b0001 << off, data {4{wdata[7:0]}}.
  - half: enable 4'b0011 << off, data {2{wdata[15:0]}}.
  - word: enable 4'b1111, data wdata.
- Loads:
  - Shift dm_dout right by 8*off.
  - Take 8/16/32 bits and extend according to req_unsigned.
  - dm_wbyte_enable = 0 during a load ACCESS.
- Stores: resp_rdata = 0, resp_fault = 0.
- Reset mid-operation: dm_we drops immediately. An in-flight write is abandoned and no response is issued. The FSM restarts in IDLE.
- Request stability: req_* inputs are only sampled at accept and may change afterwards.

Decomposition:
- Shared package mem_pkg:
  - SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2.
  - FSM state encoding: IDLE, ACCESS, RESP.
  - DM_ADDR_BITS default.
- One sub-module, dm_lane_align (pure combinational):
  - Store path: size + offset -> byte enables and replicated data.
  - Load path: dm_dout + size + offset + unsigned -> extended data.
  - Misalignment detect.
- The top level holds the FSM and registers.

Test Plan:
- Store word 0x11223344 at 0x10, then load word 0x10: dm_we high for exactly one cycle with enable 4'b1111 and dm_addr = 4. The load returns 0x11223344 with resp_valid two cycles after accept, and resp_fault = 0.
- Store byte 0xAB at 0x13, then signed byte load 0x13 and unsigned byte load 0x13: enable 4'b1000, dm_din = 0xABABABAB. Loads return 0xFFFFFFAB and 0x000000AB; the other bytes at word 4 are unchanged.
- Store half 0x8001 at 0x22, then signed half load 0x22 and unsigned half load 0x22: enable 4'b1100. Loads return 0xFFFF8001 and 0x00008001.
- Fault cases: word store at 0x06, half load at 0x01, size 3 at 0x0, and word store at 0x1000. Each gives resp_fault = 1 and resp_rdata = 0, dm_we never asserts, and memory contents are unchanged.
- Back-to-back requests with req_valid held high: accepts occur every 3 cycles, req_ready = 0 in ACCESS and RESP, and no request is lost or duplicated.
- Assert rst_n low during ACCESS of a store to 0x40: dm_we deasserts immediately, word 0x10 is unchanged, no resp_valid pulse occurs, and req_ready = 1 once reset is released.
